alu_arbiter: RTL and testbench

Shares the single 32-bit ALU between NREQ requesters, such as the decode/execute stage, the address generator and the debug port. Arbitration is round-robin. The block uses a valid/ready request handshake and a valid/ready response handshake. It drives the ALU's operation and operand inputs from internal registers, and captures the ALU result and carry/borrow flag into a held response. Each transaction takes three cycles: grant, execute, respond.

---
 rtl/alu_pkg.sv | 15 +
 rtl/alu_arbiter_rr_pick.sv | 32 +++
 rtl/alu_arbiter.sv | 127 ++++++++++++
 tb/tb_alu_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter: ALU op codes and arbiter FSM states.
package alu_pkg;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_AND = 2'b10;
   localparam logic [1:0] OP_OR  = 2'b11;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

endpackage

// File: rtl/alu_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module rr_pick #(
   parameter int NREQ = 4,
   parameter int IDW  = 2
) (
   input  logic [NREQ-1:0] req,
   input  logic [IDW-1:0]  ptr,
   output logic [NREQ-1:0] grant,
   output logic [IDW-1:0]  idx,
   output logic            any_req
);

   always_comb begin
      logic        found;
      int unsigned j;
      grant = '0;
      idx   = '0;
      found = 1'b0;
      j     = 0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         j = (32'(ptr) + k) % NREQ;
         if (!found && req[j]) begin
            found    = 1'b1;
            grant[j] = 1'b1;
            idx      = IDW'(j);
         end
      end
   end

   assign any_req = |req;

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one combinational 32-bit ALU: grant, execute, respond.
module alu_arbiter
   import alu_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int IDW  = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NREQ-1:0]      req_valid,
   output logic [NREQ-1:0]      req_ready,
   input  logic [2*NREQ-1:0]    req_op,
   input  logic [32*NREQ-1:0]   req_a,
   input  logic [32*NREQ-1:0]   req_b,
   output logic [1:0]           alu_op,
   output logic [31:0]          alu_srca,
   output logic [31:0]          alu_srcb,
   input  logic [31:0]          alu_out,
   input  logic                 alu_flag,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [IDW-1:0]       rsp_id,
   output logic [31:0]          rsp_data,
   output logic                 rsp_flag,
   output logic                 busy,
   output logic [31:0]          op_count
);

   state_t          state_q, state_d;
   logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
   logic [1:0]      op_q;
   logic [31:0]     a_q, b_q;
   logic [IDW-1:0]  id_q;
   logic [IDW-1:0]  rsp_id_q;
   logic [31:0]     rsp_data_q;
   logic            rsp_flag_q;
   logic [31:0]     op_count_q;

   logic [NREQ-1:0] grant;
   logic [IDW-1:0]  gidx;
   logic            any_req;
   logic            load;
   logic            done;

   rr_pick #(
      .NREQ (NREQ),
      .IDW  (IDW)
   ) u_pick (
      .req     (req_valid),
      .ptr     (rr_ptr_q),
      .grant   (grant),
      .idx     (gidx),
      .any_req (any_req)
   );

   always_comb begin
      state_d   = state_q;
      load      = 1'b0;
      done      = 1'b0;
      req_ready = '0;
      case (state_q)
         IDLE: begin
            if (any_req) begin
               req_ready = grant;
               load      = 1'b1;
               state_d   = EXEC;
            end
         end
         EXEC: state_d = RESP;
         RESP: begin
            if (rsp_ready) begin
               done    = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Pointer advances past the requester that just completed, not the one granted next.
   always_comb begin
      rr_ptr_d = IDW'((32'(rsp_id_q) + 32'd1) % NREQ);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         rr_ptr_q   <= '0;
         op_q       <= '0;
         a_q        <= '0;
         b_q        <= '0;
         id_q       <= '0;
         rsp_id_q   <= '0;
         rsp_data_q <= '0;
         rsp_flag_q <= 1'b0;
         op_count_q <= '0;
      end else begin
         state_q <= state_d;
         if (load) begin
            op_q <= req_op[2*gidx +: 2];
            a_q  <= req_a[32*gidx +: 32];
            b_q  <= req_b[32*gidx +: 32];
            id_q <= gidx;
         end
         if (state_q == EXEC) begin
            rsp_data_q <= alu_out;
            rsp_flag_q <= alu_flag;
            rsp_id_q   <= id_q;
         end
         if (done) begin
            op_count_q <= op_count_q + 32'd1;
            rr_ptr_q   <= rr_ptr_d;
         end
      end
   end

   assign alu_op    = op_q;
   assign alu_srca  = a_q;
   assign alu_srcb  = b_q;
   assign rsp_valid = (state_q == RESP);
   assign rsp_id    = rsp_id_q;
   assign rsp_data  = rsp_data_q;
   assign rsp_flag  = rsp_flag_q;
   assign busy      = (state_q != IDLE);
   assign op_count  = op_count_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter with a behavioural ALU as the parent-side model.
module tb_alu_arbiter;
   import alu_pkg::*;

   localparam int NREQ = 4;
   localparam int IDW  = 2;

   logic                clk = 1'b0;
   logic                rst_n = 1'b1;
   logic [NREQ-1:0]     req_valid = '0;
   logic [NREQ-1:0]     req_ready;
   logic [2*NREQ-1:0]   req_op = '0;
   logic [32*NREQ-1:0]  req_a = '0;
   logic [32*NREQ-1:0]  req_b = '0;
   logic [1:0]          alu_op;
   logic [31:0]         alu_srca, alu_srcb, alu_out;
   logic                alu_flag;
   logic                rsp_valid;
   logic                rsp_ready = 1'b1;
   logic [IDW-1:0]      rsp_id;
   logic [31:0]         rsp_data;
   logic                rsp_flag;
   logic                busy;
   logic [31:0]         op_count;

   typedef struct {
      logic [IDW-1:0] id;
      logic [31:0]    data;
      logic           flag;
   } exp_t;

   exp_t sb[$];
   int   n_chk  = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   alu_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_op    (req_op),
      .req_a     (req_a),
      .req_b     (req_b),
      .alu_op    (alu_op),
      .alu_srca  (alu_srca),
      .alu_srcb  (alu_srcb),
      .alu_out   (alu_out),
      .alu_flag  (alu_flag),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_id    (rsp_id),
      .rsp_data  (rsp_data),
      .rsp_flag  (rsp_flag),
      .busy      (busy),
      .op_count  (op_count)
   );

   logic [32:0] alu_res;
   always_comb begin
      alu_res = '0;
      case (alu_op)
         OP_ADD:  alu_res = {1'b0, alu_srca} + {1'b0, alu_srcb};
         OP_SUB:  alu_res = {1'b0, alu_srca} - {1'b0, alu_srcb};
         OP_AND:  alu_res = {1'b0, alu_srca & alu_srcb};
         default: alu_res = {1'b0, alu_srca | alu_srcb};
      endcase
   end
   assign alu_out  = alu_res[31:0];
   assign alu_flag = alu_res[32];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic push_exp(input int id, input logic [31:0] d, input logic f);
      exp_t e;
      e.id   = IDW'(id);
      e.data = d;
      e.flag = f;
      sb.push_back(e);
   endtask

   // Raise one requester, wait for its grant, then drop valid after the capture edge.
   task automatic issue(input int id, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] ed, input logic ef,
                        input bit push, output int waited);
      req_op[2*id +: 2]  = op;
      req_a[32*id +: 32] = a;
      req_b[32*id +: 32] = b;
      req_valid[id]      = 1'b1;
      waited = -1;
      for (int c = 0; c < 50; c++) begin
         @(negedge clk);
         if (req_ready[id]) begin
            waited = c;
            break;
         end
      end
      if (waited < 0) begin
         n_chk++;
         n_fail++;
         $display("FAIL grant_timeout: requester %0d saw no req_ready, required within 50 cycles", id);
      end else if (push) begin
         push_exp(id, ed, ef);
      end
      @(posedge clk);
      #1;
      req_valid[id] = 1'b0;
   endtask

   task automatic drain(input string name);
      int c;
      c = 0;
      while (sb.size() != 0 && c < 60) begin
         @(negedge clk);
         c++;
      end
      if (sb.size() != 0) begin
         n_chk++;
         n_fail++;
         $display("FAIL %s_timeout: %0d responses outstanding, required 0", name, sb.size());
         sb.delete();
      end
      @(posedge clk);
      #1;
   endtask

   // Monitor: compare each accepted response against the oldest expectation.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n && rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
               n_chk++;
               n_fail++;
               $display("FAIL rsp_unexpected: got id %0d data 0x%08h, required no response", rsp_id, rsp_data);
            end else begin
               e = sb.pop_front();
               check("rsp_id",   32'(rsp_id),   32'(e.id));
               check("rsp_data", rsp_data,      e.data);
               check("rsp_flag", 32'(rsp_flag), 32'(e.flag));
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int w;
      int ngr;
      int last;
      int order[5];
      order = '{0, 1, 2, 3, 0};

      // Reset values
      #1 rst_n = 1'b0;
      #1;
      check("rst_req_ready", 32'(req_ready), 32'd0);
      check("rst_busy",      32'(busy),      32'd0);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_rsp_id",    32'(rsp_id),    32'd0);
      check("rst_rsp_data",  rsp_data,       32'd0);
      check("rst_rsp_flag",  32'(rsp_flag),  32'd0);
      check("rst_op_count",  op_count,       32'd0);
      check("rst_alu_op",    32'(alu_op),    32'd0);
      check("rst_alu_srca",  alu_srca,       32'd0);
      check("rst_alu_srcb",  alu_srcb,       32'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Single ADD with carry out, latency check
      issue(0, OP_ADD, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b1, 1'b1, w);
      check("add_grant_wait", 32'(w), 32'd0);
      check("add_exec_valid", 32'(rsp_valid), 32'd0);
      check("add_exec_busy",  32'(busy),      32'd1);
      check("add_alu_srca",   alu_srca,       32'hFFFF_FFFF);
      @(posedge clk);
      #1;
      check("add_resp_valid", 32'(rsp_valid), 32'd1);
      @(posedge clk);
      #1;
      check("add_done_valid", 32'(rsp_valid), 32'd0);
      check("add_op_count",   op_count,       32'd1);
      check("add_idle_busy",  32'(busy),      32'd0);
      check("add_srca_hold",  alu_srca,       32'hFFFF_FFFF);

      // SUB with borrow, then AND
      issue(2, OP_SUB, 32'd3, 32'd5, 32'hFFFF_FFFE, 1'b1, 1'b1, w);
      drain("sub");
      check("sub_op_count", op_count, 32'd2);
      issue(3, OP_AND, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0, 1'b1, w);
      drain("and");
      check("and_op_count", op_count, 32'd3);

      // Round-robin with all four requesters held valid
      req_op[1:0] = OP_ADD; req_a[31:0]   = 32'd10;         req_b[31:0]   = 32'd20;
      req_op[3:2] = OP_SUB; req_a[63:32]  = 32'd100;        req_b[63:32]  = 32'd1;
      req_op[5:4] = OP_OR;  req_a[95:64]  = 32'h0000_000F;  req_b[95:64]  = 32'h0000_00F0;
      req_op[7:6] = OP_AND; req_a[127:96] = 32'hFFFF_0000;  req_b[127:96] = 32'h1234_5678;
      push_exp(0, 32'd30,        1'b0);
      push_exp(1, 32'd99,        1'b0);
      push_exp(2, 32'h0000_00FF, 1'b0);
      push_exp(3, 32'h1234_0000, 1'b0);
      push_exp(0, 32'd30,        1'b0);
      req_valid = 4'hF;
      ngr  = 0;
      last = 0;
      for (int c = 0; c < 40 && ngr < 5; c++) begin
         @(negedge clk);
         if (req_ready != '0) begin
            check("rr_onehot", 32'($onehot(req_ready)), 32'd1);
            check("rr_order",  32'(req_ready), 32'd1 << order[ngr]);
            if (ngr > 0) check("rr_gap", 32'(c - last), 32'd3);
            last = c;
            ngr++;
         end
      end
      check("rr_grants", 32'(ngr), 32'd5);
      @(posedge clk);
      #1 req_valid = '0;
      drain("rr");
      check("rr_op_count", op_count, 32'd8);

      // Backpressure in RESP
      rsp_ready = 1'b0;
      issue(1, OP_ADD, 32'h8000_0000, 32'h8000_0000, 32'h0, 1'b1, 1'b1, w);
      @(posedge clk);
      #1;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         check("bp_valid",     32'(rsp_valid), 32'd1);
         check("bp_data",      rsp_data,       32'h0);
         check("bp_flag",      32'(rsp_flag),  32'd1);
         check("bp_id",        32'(rsp_id),    32'd1);
         check("bp_req_ready", 32'(req_ready), 32'd0);
         check("bp_busy",      32'(busy),      32'd1);
         check("bp_op_count",  op_count,       32'd8);
      end
      @(posedge clk);
      #1 rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      check("bp_done_valid", 32'(rsp_valid), 32'd0);
      check("bp_done_count", op_count,       32'd9);
      @(posedge clk);
      #1;
      check("bp_count_once", op_count, 32'd9);

      // Asynchronous reset during EXEC aborts the transaction
      issue(3, OP_OR, 32'd1, 32'd2, 32'd3, 1'b0, 1'b0, w);
      check("abort_exec_busy", 32'(busy), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("abort_rsp_valid", 32'(rsp_valid), 32'd0);
      check("abort_busy",      32'(busy),      32'd0);
      check("abort_op_count",  op_count,       32'd0);
      check("abort_alu_srca",  alu_srca,       32'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         check("post_rst_ready", 32'(req_ready), 32'd0);
         check("post_rst_busy",  32'(busy),      32'd0);
      end
      @(posedge clk);
      #1;
      req_op[1:0] = OP_SUB; req_a[31:0]   = 32'd7; req_b[31:0]   = 32'd2;
      req_op[7:6] = OP_ADD; req_a[127:96] = 32'd1; req_b[127:96] = 32'd1;
      req_valid = 4'b1001;
      @(negedge clk);
      check("post_rst_grant", 32'(req_ready), 32'h1);
      push_exp(0, 32'd5, 1'b0);
      @(posedge clk);
      #1 req_valid = '0;
      drain("post_rst");
      check("post_rst_count", op_count, 32'd1);

      // op_count wraps to zero
      force dut.op_count_q = 32'hFFFF_FFFF;
      #1;
      release dut.op_count_q;
      #1;
      check("wrap_preload", op_count, 32'hFFFF_FFFF);
      issue(2, OP_SUB, 32'd0, 32'd1, 32'hFFFF_FFFF, 1'b1, 1'b1, w);
      drain("wrap");
      check("wrap_op_count", op_count, 32'd0);

      check("sb_empty", 32'(sb.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
